// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps one imem request outstanding, queues returned words.
// Define FETCH_BTFN_PREDICT_EN to build static backward-taken prediction for B-type branches.
module if_fetch_stage #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        inst_ready,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  output logic        pred_taken
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0] Nop  = 32'h0000_0013;

  typedef enum logic [1:0] {StIdle, StWait, StDrop} state_e;

  state_e          state_q, state_d;
  logic [63:0]     pc_q, pc_d;
  logic [63:0]     req_pc_q, req_pc_d;
  logic            req_q, req_d;
  logic [CntW-1:0] count_q, count_d, count_after_pop;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [63:0]     next_pc;
  logic            push, pop, issue;

  logic [31:0] word_mem [FIFO_DEPTH];
  logic [63:0] pc_mem   [FIFO_DEPTH];

  assign inst_valid      = (count_q != '0);
  assign pop             = inst_valid && inst_ready && !redirect_valid;
  assign push            = (state_q == StWait) && imem_rvalid && !redirect_valid;
  // A same-cycle pop frees a slot, so a full queue can still launch a fetch.
  assign count_after_pop = count_q - CntW'(pop);
  assign issue           = (state_q == StIdle) && !redirect_valid &&
                           (count_after_pop < CntW'(FIFO_DEPTH));

`ifdef FETCH_BTFN_PREDICT_EN
  logic        pred_mem [FIFO_DEPTH];
  logic        bwd_branch;
  logic [63:0] b_offset;

  assign bwd_branch = (imem_rdata[6:0] == 7'b1100011) && imem_rdata[31];
  assign b_offset   = {{51{imem_rdata[31]}}, imem_rdata[31], imem_rdata[7],
                       imem_rdata[30:25], imem_rdata[11:8], 1'b0};
  assign next_pc    = req_pc_q + (bwd_branch ? b_offset : 64'd4);
  assign pred_taken = inst_valid && pred_mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) pred_mem[wr_ptr_q] <= bwd_branch;
  end
`else
  assign next_pc    = req_pc_q + 64'd4;
  assign pred_taken = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (issue) state_d = StWait;
      StWait: begin
        if (imem_rvalid)         state_d = StIdle;
        else if (redirect_valid) state_d = StDrop;
      end
      StDrop:  if (imem_rvalid) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    req_d    = issue;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (issue) req_pc_d = pc_q;
    if (redirect_valid) begin
      pc_d     = redirect_pc;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) begin
        pc_d     = next_pc;
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
      req_q    <= 1'b0;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      req_q    <= req_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      word_mem[wr_ptr_q] <= imem_rdata;
      pc_mem[wr_ptr_q]   <= req_pc_q;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = req_pc_q;
  assign inst      = inst_valid ? word_mem[rd_ptr_q] : Nop;
  assign inst_pc   = inst_valid ? pc_mem[rd_ptr_q] : 64'h0;

endmodule
